// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes the power-on reset, debounces a soft-reset button and
// releases per-domain resets lowest index first, optionally waiting for each domain's ACK.
//
// state    | meaning
// HOLD     | all outputs asserted, counting the hold time
// RELEASE  | not a resident state: the edge that clears RST_OUT[k] and enters WAIT_DLY
// WAIT_DLY | counting DELAY after stage k was released
// WAIT_ACK | waiting up to TIMEOUT cycles for ACK[k]
// RUN      | all stages released and complete
module reset_sequencer #(
    parameter int STAGES   = 3,
    parameter int HOLD     = 10,
    parameter int DELAY    = 40,
    parameter int DEBOUNCE = 16,
    parameter int TIMEOUT  = 100,
    parameter logic [STAGES-1:0] ACK_MASK = '0,
    localparam int SW = $clog2(STAGES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN,
    input  logic [STAGES-1:0] ACK,
    output logic [STAGES-1:0] RST_OUT,
    output logic              READY,
    output logic              ERR,
    output logic [SW-1:0]     STAGE
);
    localparam int KW   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int MAXC = (HOLD > DELAY) ? ((HOLD > TIMEOUT) ? HOLD : TIMEOUT)
                                         : ((DELAY > TIMEOUT) ? DELAY : TIMEOUT);
    localparam int CW   = $clog2(MAXC + 1);
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_DLY  = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic [1:0]    rst_sync;
    logic          rst_ok;
    logic [1:0]    btn_sync;
    logic          btn_s;
    logic [DW-1:0] db_cnt;
    logic          armed;
    logic          press;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;
    logic [KW-1:0] rel_idx;
    logic          done;
    logic          timed_out;
    logic          last;
    logic          start;

    assign rst_ok = rst_sync[1];
    assign btn_s  = btn_sync[1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    // While armed the counter measures a high run; after a press it measures the low run needed to re-arm.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            btn_sync <= 2'b00;
            db_cnt   <= '0;
            armed    <= 1'b1;
            press    <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], BTN};
            press    <= 1'b0;
            if (armed ? !btn_s : btn_s) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                armed  <= !armed;
                press  <= armed;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    always_comb begin
        done      = 1'b0;
        timed_out = 1'b0;
        case (state)
            S_DLY: done = (cnt == '0) && (!ACK_MASK[k] || ACK[k]);
            S_ACK: begin
                timed_out = !ACK[k] && (cnt == '0);
                done      = ACK[k] || (cnt == '0);
            end
            default: ;
        endcase
    end

    assign last    = (k == KW'(STAGES - 1));
    assign start   = (state == S_HOLD) && (cnt == '0);
    assign rel_idx = start ? '0 : k + KW'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_HOLD;
            cnt     <= CW'(HOLD - 1);
            k       <= '0;
            RST_OUT <= '1;
            READY   <= 1'b0;
            ERR     <= 1'b0;
            STAGE   <= '0;
        end else if (rst_ok) begin
            // A registered press outranks any completion on the same edge; ERR survives it.
            if (timed_out && !press) ERR <= 1'b1;
            if (press) begin
                state   <= S_HOLD;
                cnt     <= CW'(HOLD - 1);
                k       <= '0;
                RST_OUT <= '1;
                READY   <= 1'b0;
                STAGE   <= '0;
            end else if (start || (done && !last)) begin
                RST_OUT[rel_idx] <= 1'b0;
                STAGE            <= SW'(rel_idx);
                k                <= rel_idx;
                state            <= S_DLY;
                cnt              <= CW'(DELAY - 1);
            end else if (done) begin
                state <= S_RUN;
                READY <= 1'b1;
                STAGE <= SW'(STAGES);
            end else if (state == S_DLY && cnt == '0) begin
                state <= S_ACK;
                cnt   <= CW'(TIMEOUT - 1);
            end else if (state != S_RUN) begin
                cnt <= cnt - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed timing table, button/reset corner
// sequences, and a long randomized run against an event-time reference model.
module tb_reset_sequencer;
    localparam int STAGES   = 3;
    localparam int HOLD     = 10;
    localparam int DELAY    = 40;
    localparam int DEBOUNCE = 16;
    localparam int TIMEOUT  = 100;
    localparam logic [2:0] ACK_MASK = 3'b010;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN = 1'b0;
    logic [2:0] ACK = 3'b000;
    logic [2:0] RST_OUT;
    logic       READY;
    logic       ERR;
    logic [1:0] STAGE;

    reset_sequencer #(
        .STAGES(STAGES), .HOLD(HOLD), .DELAY(DELAY), .DEBOUNCE(DEBOUNCE),
        .TIMEOUT(TIMEOUT), .ACK_MASK(ACK_MASK)
    ) dut (
        .CLK(CLK), .RST(RST), .BTN(BTN), .ACK(ACK),
        .RST_OUT(RST_OUT), .READY(READY), .ERR(ERR), .STAGE(STAGE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges counted from reset release; each phase ends at an absolute edge.
    int m_cyc, m_phase, m_due, m_k, m_nrel;
    int hi_run, lo_run;
    bit m_ready, m_err, m_press, armed, h1, h2;

    task automatic model_reset();
        m_cyc = 0; m_phase = 0; m_due = 2 + HOLD; m_k = 0; m_nrel = 0;
        m_ready = 0; m_err = 0; m_press = 0; h1 = 0; h2 = 0;
        hi_run = 0; lo_run = 0; armed = 1;
    endtask

    task automatic m_release(input int j);
        m_k = j; m_nrel = j + 1; m_phase = 1; m_due = m_cyc + DELAY;
    endtask

    task automatic m_complete();
        if (m_k < STAGES - 1) m_release(m_k + 1);
        else begin m_ready = 1; m_phase = 3; end
    endtask

    task automatic model_step();
        bit s, ackk, newpress;
        m_cyc++;
        ackk = ACK[m_k];
        if (m_cyc >= 3) begin
            if (m_press) begin
                m_phase = 0; m_due = m_cyc + HOLD; m_nrel = 0; m_k = 0; m_ready = 0;
            end else if (m_phase == 0) begin
                if (m_cyc == m_due) m_release(0);
            end else if (m_phase == 1) begin
                if (m_cyc == m_due) begin
                    if (!ACK_MASK[m_k] || ackk) m_complete();
                    else begin m_phase = 2; m_due = m_cyc + TIMEOUT; end
                end
            end else if (m_phase == 2) begin
                if (ackk) m_complete();
                else if (m_cyc == m_due) begin m_err = 1; m_complete(); end
            end
        end
        s = h2; h2 = h1; h1 = BTN;
        if (s) begin hi_run++; lo_run = 0; end
        else begin lo_run++; hi_run = 0; end
        newpress = 0;
        if (armed && hi_run == DEBOUNCE) begin newpress = 1; armed = 0; end
        else if (!armed && lo_run == DEBOUNCE) armed = 1;
        m_press = newpress;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) model_reset();
            else model_step();
        end
    end

    bit chk_en = 0;
    logic [2:0] exp_rst, inv;
    logic [6:0] got_v, exp_v;
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                for (int i = 0; i < STAGES; i++) exp_rst[i] = (i >= m_nrel);
                got_v = {RST_OUT, READY, ERR, STAGE};
                exp_v = {exp_rst, m_ready, m_err, m_ready ? 2'd3 : 2'(m_k)};
                check("outputs{rst_out,ready,err,stage}", int'(got_v), int'(exp_v));
                inv = ~RST_OUT;
                check("thermometer", int'((inv & (inv + 3'd1)) == 3'd0), 1);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic power_on(input logic [2:0] a);
        RST = 1'b0; ACK = a; BTN = 1'b0;
        repeat (5) tick();
        RST = 1'b1;
    endtask

    task automatic watch(input int btn_len, input int rise, input bit from_soft,
                         output int t_set, output int f0, output int f1, output int f2, output int fr);
        bit seen;
        seen = !from_soft;
        t_set = -1; f0 = -1; f1 = -1; f2 = -1; fr = -1;
        for (int i = 0; i < 500; i++) begin
            BTN = (i < btn_len);
            if (rise >= 0 && m_cyc + 1 >= rise) ACK[1] = 1'b1;
            tick();
            if (!seen && RST_OUT == 3'b111) begin seen = 1; t_set = m_cyc; end
            if (seen) begin
                if (f0 < 0 && !RST_OUT[0]) f0 = m_cyc;
                if (f1 < 0 && !RST_OUT[1]) f1 = m_cyc;
                if (f2 < 0 && !RST_OUT[2]) f2 = m_cyc;
                if (fr < 0 && READY) fr = m_cyc;
            end
            if (fr >= 0 && i >= btn_len) break;
        end
        BTN = 1'b0;
    endtask

    typedef struct {
        logic [2:0] ack;
        int rise;
        int f0, f1, f2, fr;
        logic err;
    } vec_t;

    vec_t tab[6];
    int ts, f0, f1, f2, fr, c0, s_exp;
    bit ok, btn_lvl;
    int btn_left, ack_mode;

    initial begin
        tab[0] = '{3'b111,  0, 12, 52,  92, 132, 1'b0};
        tab[1] = '{3'b101, 120, 12, 52, 120, 160, 1'b0};
        tab[2] = '{3'b000,  92, 12, 52,  92, 132, 1'b0};
        tab[3] = '{3'b000,  93, 12, 52,  93, 133, 1'b0};
        tab[4] = '{3'b101, 191, 12, 52, 191, 231, 1'b0};
        tab[5] = '{3'b101,  -1, 12, 52, 192, 232, 1'b1};

        #1;
        RST = 1'b0;
        chk_en = 1;
        #1;
        check("reset_rst_out", int'(RST_OUT), 7);
        check("reset_ready", int'(READY), 0);
        check("reset_stage", int'(STAGE), 0);

        for (int r = 0; r < 6; r++) begin
            power_on(tab[r].ack);
            watch(0, tab[r].rise, 0, ts, f0, f1, f2, fr);
            check($sformatf("rec%0d_fall0", r), f0, tab[r].f0);
            check($sformatf("rec%0d_fall1", r), f1, tab[r].f1);
            check($sformatf("rec%0d_fall2", r), f2, tab[r].f2);
            check($sformatf("rec%0d_ready", r), fr, tab[r].fr);
            check($sformatf("rec%0d_err", r), int'(ERR), int'(tab[r].err));
            check($sformatf("rec%0d_stage", r), int'(STAGE), 3);
        end

        // Short pulse and bounce in RUN must not soft-reset.
        ok = 1;
        for (int i = 0; i < 60; i++) begin
            BTN = (i < 10);
            tick();
            if (!READY || RST_OUT != 3'b000) ok = 0;
        end
        check("btn_short_no_reset", int'(ok), 1);
        ok = 1;
        for (int i = 0; i < 80; i++) begin
            BTN = (i < 50) && ((i / 3) % 2 == 0);
            tick();
            if (!READY || RST_OUT != 3'b000) ok = 0;
        end
        check("btn_bounce_no_reset", int'(ok), 1);

        // Long hold: one soft reset, ERR kept, replay at 10/40/40/40, no retrigger.
        ACK = 3'b111;
        c0 = m_cyc;
        s_exp = c0 + 1 + DEBOUNCE + 2;
        watch(60, 0, 1, ts, f0, f1, f2, fr);
        check("soft_set_edge", ts, s_exp);
        check("soft_fall0", f0, s_exp + 10);
        check("soft_fall1", f1, s_exp + 50);
        check("soft_fall2", f2, s_exp + 90);
        check("soft_ready", fr, s_exp + 130);
        check("soft_err_kept", int'(ERR), 1);

        // Asynchronous clear with ERR set, no clock edge needed.
        @(posedge CLK); #2;
        RST = 1'b0;
        #1;
        check("async_err_clear", int'(ERR), 0);
        check("async_rst_out", int'(RST_OUT), 7);
        check("async_ready", int'(READY), 0);
        repeat (3) tick();
        RST = 1'b1;
        for (int i = 0; i < 100 && m_cyc < 70; i++) tick();
        check("mid_seq_state", int'(RST_OUT), 3'b100);
        RST = 1'b0;
        #1;
        check("mid_rst_out", int'(RST_OUT), 7);
        check("mid_ready", int'(READY), 0);
        check("mid_stage", int'(STAGE), 0);
        repeat (3) tick();
        RST = 1'b1;
        watch(0, 0, 0, ts, f0, f1, f2, fr);
        check("mid_replay_fall0", f0, 12);
        check("mid_replay_fall1", f1, 52);
        check("mid_replay_fall2", f2, 92);
        check("mid_replay_ready", fr, 132);

        // Press landing on the stage-1 release edge wins.
        power_on(3'b111);
        for (int i = 0; i < 100 && m_cyc < 33; i++) tick();
        watch(30, 0, 1, ts, f0, f1, f2, fr);
        check("collide_set_edge", ts, 52);
        check("collide_fall1", f1, 102);
        check("collide_ready", fr, 182);

        // Randomized run against the model.
        btn_lvl = 0; btn_left = 0; ack_mode = 0;
        for (int i = 0; i < 20000; i++) begin
            if (btn_left == 0) begin
                btn_lvl = !btn_lvl;
                btn_left = btn_lvl ? int'($urandom_range(1, 30)) : int'($urandom_range(20, 400));
            end
            btn_left--;
            BTN = btn_lvl;
            if (i % 256 == 0) ack_mode = int'($urandom_range(0, 2));
            ACK[0] = 1'($urandom_range(0, 1));
            ACK[2] = 1'($urandom_range(0, 1));
            ACK[1] = (ack_mode == 1) ? 1'b1 :
                     (ack_mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
            if ($urandom_range(0, 2999) == 0) begin
                RST = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                RST = 1'b1;
            end
            tick();
        end

        BTN = 1'b0;
        repeat (2) tick();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Synthesizable reset controller for FPGA designs. Turns an external asynchronous power-on reset and a push-button soft-reset request into an ordered set of per-domain reset outputs.
- Releases downstream blocks one at a time, lowest index first, with a programmable gap between releases.
- Can hold off the next release until a block acknowledges it is alive; flags an error if that acknowledgement never arrives.
- Sits at top level, directly below the clock source; all other blocks take their reset from RST_OUT.

Parameters:
- STAGES, 3, number of reset domains (1..8).
- HOLD, 10, minimum CLK cycles all outputs stay asserted after reset is released (>=1).
- DELAY, 40, CLK cycles between releasing stage k and evaluating stage k completion (>=1).
- DEBOUNCE, 16, consecutive synchronized-high cycles of BTN needed to register a press (>=2).
- TIMEOUT, 100, CLK cycles to wait for ACK[k] after DELAY before giving up (>=1).
- ACK_MASK, all zeros, STAGES bits; bit k=1 means stage k completion also requires ACK[k].

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset, external/power-on.
- BTN  in  1  raw asynchronous push button, active-high, soft-reset request.
- ACK  in  STAGES  per-stage alive/ready flags, synchronous to CLK, level-sensitive.
- RST_OUT  out  STAGES  per-domain resets, active-high, registered.
- READY  out  1  high when all stages are released and complete.
- ERR  out  1  sticky: some ACK timed out since last RST.
- STAGE  out  ceil(log2(STAGES+1))  index of the stage currently being sequenced; equals STAGES once READY.

Behaviour:
- RST low (any time, asynchronously):
  - RST_OUT = all ones, READY=0, ERR=0, STAGE=0.
  - FSM goes to HOLD; all counters and synchronizer flops cleared.
- RST deassertion passes through a 2-flop synchronizer.
  - Edge e=1 is the first rising CLK edge with RST high.
  - Synchronized reset releases at e=2.
  - HOLD counting starts at e=2.
- FSM states: HOLD, RELEASE, WAIT_DLY, WAIT_ACK, RUN.
- HOLD: count HOLD cycles, then go to RELEASE with k=0.
  - RST_OUT[0] falls at edge 2+HOLD.
- RELEASE: clear RST_OUT[k] (registered, visible on the same edge the state is entered); set STAGE=k; go to WAIT_DLY.
- WAIT_DLY: count DELAY cycles from the edge RST_OUT[k] fell. Then:
  - if ACK_MASK[k]=0 -> stage complete;
  - if ACK_MASK[k]=1 and ACK[k]=1 -> stage complete on that edge;
  - otherwise -> WAIT_ACK.
- WAIT_ACK: complete on the first edge where ACK[k]=1. If TIMEOUT cycles elapse first, set ERR=1 and treat the stage as complete.
- On stage complete:
  - if k<STAGES-1: release stage k+1 on the same edge;
  - else: READY=1, STAGE=STAGES, go to RUN.
- Release order invariant: RST_OUT is a thermometer. RST_OUT[i]=0 implies RST_OUT[j]=0 for all j<i. No stage is ever released before a lower one.
- BTN handling:
  - 2-flop synchronizer, then a debounce counter.
  - Counter increments while the synchronized BTN is high and clears when it is low.
  - A press registers on the edge the counter reaches DEBOUNCE.
  - One-shot: no further press until the synchronized BTN has been low for DEBOUNCE cycles.
- Soft reset (registered press), accepted in any state including mid-sequence:
  - next edge: RST_OUT = all ones, READY=0, STAGE=0, enter HOLD;
  - ERR is preserved; sequence restarts from HOLD.
- Simultaneous events: an RST assertion overrides everything. A press on the same edge as a stage completion wins: outputs reassert.
- ACK changes during WAIT_DLY are ignored; only the level at the evaluation edge matters.
- ACK for stages not yet released is ignored.

Test Plan (STAGES=3, HOLD=10, DELAY=40, DEBOUNCE=16, TIMEOUT=100, ACK_MASK=010):
- Power-on, ACK=111: RST low 5 cycles, then high -> RST_OUT=111 until e12; RST_OUT[0] falls e12, [1] falls e52, [2] falls e92; READY=1 at e132; ERR=0; STAGE reads 0,1,2,3 in turn.
- ACK[1] held low, raised at e120 -> RST_OUT[2] falls at the e120 edge; READY=1 at e160; ERR=0.
- ACK[1] never rises -> ERR=1 and RST_OUT[2] falls at e192; READY=1 at e232; ERR stays 1 until RST.
- In RUN, BTN pulse high for 10 cycles -> no change. BTN held 30 cycles -> RST_OUT=111 and READY=0 one edge after the debounce count hits 16; full sequence replays with the same 10/40/40/40 spacing; ERR unchanged. Holding BTN does not retrigger.
- RST pulsed low at e70 (mid-sequence) -> RST_OUT=111, READY=0, ERR=0 immediately, without waiting for a CLK edge; sequence restarts with identical timing after release.
- Assert the thermometer invariant on RST_OUT every cycle in all of the above; check BTN bounce (alternating 3-cycle high/low for 50 cycles) causes no soft reset.
